beverage_vending_ctrl: RTL

Parametrised multi-product beverage vending controller, the next-generation generalisation of the team's two-product tea/coffee machine. It accumulates 5- and 10-unit coin credit and serves any of NUM_PROD products at per-product prices, gated by water and per-product stock sensors. It returns change as a train of 5-unit coin pulses and supports cancel/refund. It sits between the coin acceptor/button panel and the dispenser/coin-return actuators.

---
 rtl/beverage_vending_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/beverage_vending_ctrl.sv
// Multi-product beverage vending controller: coin credit, per-product pricing, 5-unit change train.
// Optional inactivity refund is enabled by defining VEND_TIMEOUT_EN.
module beverage_vending_ctrl #(
  parameter int unsigned                      NUM_PROD       = 2,
  parameter int unsigned                      CREDIT_W       = 6,
  parameter logic [NUM_PROD*CREDIT_W-1:0]     PRICE_LIST     = {6'd10, 6'd5},
  parameter int unsigned                      MAX_CREDIT     = 30,
  parameter int unsigned                      SERVE_CYCLES   = 4,
  parameter int unsigned                      TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic                coin_type,
  input  logic [NUM_PROD-1:0] sel,
  input  logic                cancel,
  input  logic                water_ok,
  input  logic [NUM_PROD-1:0] stock_ok,
  output logic [NUM_PROD-1:0] serve,
  output logic                change,
  output logic                coin_reject,
  output logic                err_supply,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned SRV_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam logic [CREDIT_W-1:0] FIVE = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] TEN  = CREDIT_W'(10);
  localparam logic [CREDIT_W:0]   MAX_SUM = (CREDIT_W + 1)'(MAX_CREDIT);

  if (NUM_PROD < 1 || NUM_PROD > 8 || SERVE_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
      MAX_CREDIT >= (1 << CREDIT_W)) begin : g_param_check
    $error("beverage_vending_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_SERVE, S_CHANGE} state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [NUM_PROD-1:0] serve_q, serve_d;
  logic [SRV_W-1:0]    srv_cnt_q, srv_cnt_d;
  logic                change_q, change_d;
  logic                coin_reject_q, coin_reject_d;
  logic                err_supply_q, err_supply_d;
  logic                busy_q, busy_d;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            activity;
`endif

  logic [CREDIT_W-1:0] sel_price;
  logic                sel_stock;
  logic                sel_onehot;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                refund;

  // Price and stock of the selected product (only meaningful when sel is one-hot)
  always_comb begin
    sel_price = '0;
    sel_stock = 1'b0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (sel[i]) begin
        sel_price = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
        sel_stock = stock_ok[i];
      end
    end
  end

  assign sel_onehot = $onehot(sel);
  assign coin_sum   = {1'b0, credit_q} + {1'b0, (coin_type ? TEN : FIVE)};
  assign coin_fits  = (coin_sum <= MAX_SUM);

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    serve_d       = serve_q;
    srv_cnt_d     = srv_cnt_q;
    change_d      = 1'b0;
    coin_reject_d = 1'b0;
    err_supply_d  = 1'b0;
    refund        = 1'b0;
`ifdef VEND_TIMEOUT_EN
    to_cnt_d      = '0;
    activity      = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (cancel && state_q == S_CREDIT) begin
          refund        = 1'b1;
          coin_reject_d = coin_valid;
        end else if (sel_onehot && !(water_ok && sel_stock)) begin
          err_supply_d  = 1'b1;
          coin_reject_d = coin_valid;
        end else if (sel_onehot && credit_q >= sel_price) begin
          credit_d      = credit_q - sel_price;
          serve_d       = sel;
          srv_cnt_d     = '0;
          state_d       = S_SERVE;
          coin_reject_d = coin_valid;
        end else if (coin_valid) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = S_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      S_SERVE: begin
        coin_reject_d = coin_valid;
        if (srv_cnt_q == SRV_W'(SERVE_CYCLES - 1)) begin
          serve_d = '0;
          if (credit_q != '0) begin
            state_d  = S_CHANGE;
            change_d = 1'b1;
            credit_d = credit_q - FIVE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          srv_cnt_d = srv_cnt_q + SRV_W'(1);
        end
      end
      S_CHANGE: begin
        // Each 5-unit coin is a high cycle followed by a low cycle
        coin_reject_d = coin_valid;
        if (!change_q) begin
          if (credit_q == '0) begin
            state_d = S_IDLE;
          end else begin
            change_d = 1'b1;
            credit_d = credit_q - FIVE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef VEND_TIMEOUT_EN
    activity = !refund && ((sel != '0) || (coin_valid && coin_fits));
    if (state_q == S_CREDIT && !activity && !refund) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        refund = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif

    // Refund starts the change train immediately; the first pulse debits 5
    if (refund) begin
      state_d  = S_CHANGE;
      change_d = 1'b1;
      credit_d = credit_q - FIVE;
    end

    busy_d = (state_d == S_SERVE) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      serve_q       <= '0;
      srv_cnt_q     <= '0;
      change_q      <= 1'b0;
      coin_reject_q <= 1'b0;
      err_supply_q  <= 1'b0;
      busy_q        <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      serve_q       <= serve_d;
      srv_cnt_q     <= srv_cnt_d;
      change_q      <= change_d;
      coin_reject_q <= coin_reject_d;
      err_supply_q  <= err_supply_d;
      busy_q        <= busy_d;
`ifdef VEND_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
`endif
    end
  end

  assign serve       = serve_q;
  assign change      = change_q;
  assign coin_reject = coin_reject_q;
  assign err_supply  = err_supply_q;
  assign busy        = busy_q;
  assign credit      = credit_q;

endmodule
